wb_port_sequencer: RTL and testbench
====================================

Name: wb_port_sequencer

Overview:
- Sequences the register-file write port (WE3/A3/WD3 select) and the data-memory handshake for a MIPS core whose data memory has variable latency.
- Non-memory instructions write back in the same cycle, with no stall.
- lw/sw instructions stall the PC while the block runs a request/grant/read-valid handshake. It then issues the lw writeback through the WD3 select mux, with WD3_SEL=1 choosing memory data.
- Sits between the main decoder, data memory, register file and PC register.

Parameters:
DATA_WIDTH, 32, datapath and memory data/address width
REG_ADDR_WIDTH, 5, register-file address width
TIMEOUT_CYCLES, 16, maximum cycles in REQ+WAIT before bus error; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; synchronous, active-high
INSTR_VALID  in  1  current instruction valid
REG_WRITE  in  1  decoder RegWrite
MEM_TO_REG  in  1  decoder MemtoReg (lw)
MEM_WRITE  in  1  decoder MemWrite (sw)
WRITE_REG  in  REG_ADDR_WIDTH  destination register
ALU_RESULT  in  DATA_WIDTH  ALU result / effective address
WRITE_DATA  in  DATA_WIDTH  store data (RD2)
MEM_REQ  out  1  memory request
MEM_WE  out  1  1 = store
MEM_ADDR  out  DATA_WIDTH  latched address
MEM_WDATA  out  DATA_WIDTH  latched store data
MEM_GNT  in  1  request accepted
MEM_RVALID  in  1  read data valid
MEM_RDATA  in  DATA_WIDTH  read data
REG_FILE_WE3  out  1  register-file write enable
REG_FILE_A3  out  REG_ADDR_WIDTH  write address
REG_FILE_WD3_SEL  out  1  to WD3 mux: 1 = Data_Mem_RD, 0 = ALU_Result
DATA_MEM_RD_Q  out  DATA_WIDTH  captured load data, feeds mux Data_Mem_RD
STALL  out  1  hold PC/instruction
BUS_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE.
  - All latches, DATA_MEM_RD_Q, the timeout counter and BUS_ERR are cleared to 0.
  - Every combinational output is 0 in IDLE when INSTR_VALID=0.
- Decode: mem_op = INSTR_VALID & (MEM_TO_REG | MEM_WRITE). If both MEM_TO_REG and MEM_WRITE are high, treat the instruction as a store.
- IDLE:
  - Non-mem_op:
    - REG_FILE_WE3 = INSTR_VALID & REG_WRITE & (WRITE_REG != 0).
    - A3 = WRITE_REG, WD3_SEL = 0, STALL = 0, combinational.
  - mem_op:
    - STALL = 1, WE3 = 0.
    - Latch ALU_RESULT, WRITE_DATA, WRITE_REG and is_store.
    - Clear the counter; go to REQ.
- REQ:
  - MEM_REQ = 1; MEM_WE = is_store; addr/wdata come from the latches; STALL = 1.
  - On MEM_GNT:
    - Store → WB.
    - Load with MEM_RVALID in the same cycle → capture MEM_RDATA, go to WB.
    - Load otherwise → WAIT.
  - MEM_REQ holds stable until granted.
- WAIT:
  - MEM_REQ = 0, STALL = 1.
  - On MEM_RVALID: DATA_MEM_RD_Q <= MEM_RDATA; go to WB.
  - MEM_RVALID outside WAIT/REQ-granted is ignored.
- WB, exactly one cycle:
  - STALL = 0, so the PC advances at this edge.
  - Load: WE3 = (latched rd != 0), A3 = latched rd, WD3_SEL = 1.
  - Store: WE3 = 0.
  - Decoder inputs are ignored in WB. Next state is IDLE, which sees the next instruction.
- Latency:
  - ALU instruction: 0 extra cycles.
  - Memory op: 2 + grant wait + rvalid wait cycles of stall. Best-case load (GNT and RVALID in the first REQ cycle) is IDLE→REQ→WB, i.e. 2 stall cycles.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without completion, set BUS_ERR (sticky until RST) and go to WB with WE3 forced to 0.
  - DATA_MEM_RD_Q is unchanged on timeout.
- RST mid-operation: the FSM returns to IDLE immediately, MEM_REQ drops the same cycle, and any pending writeback is discarded.
- Register $0 is never written.

Decomposition:
- Package wb_seq_pkg holds:
  - state enum {IDLE, REQ, WAIT, WB} (2-bit).
  - REG_ZERO constant.
- No sub-module; the timeout counter is inline. The WD3 mux stays external.

Test Plan:
- R-type add, REG_WRITE=1, WRITE_REG=8, INSTR_VALID=1 → same cycle WE3=1, A3=8, WD3_SEL=0, STALL=0; no MEM_REQ.
- lw rd=9, addr 0x40; memory GNT 2 cycles after REQ, RVALID 3 cycles later with 0xDEADBEEF → MEM_ADDR=0x40 held during REQ. In WB: WE3=1, A3=9, WD3_SEL=1, DATA_MEM_RD_Q=0xDEADBEEF. STALL high in every cycle before WB.
- sw addr 0x10, data 0x1234, GNT in the first REQ cycle → MEM_WE=1, MEM_WDATA=0x1234, then WB with WE3=0; total stall 2 cycles.
- lw with GNT and RVALID in the same REQ cycle → WB on the next cycle. Also lw rd=0 → WB with WE3=0.
- Load never answered, TIMEOUT_CYCLES=16 → BUS_ERR=1 after 16 REQ/WAIT cycles, WB with WE3=0, BUS_ERR stays 1 until RST.
- RST asserted while in WAIT → next cycle state IDLE, all outputs 0, and no writeback occurs even if RVALID arrives later.

Source files
------------

// File: rtl/wb_port_sequencer_pkg.sv
// Shared types and constants for the writeback-port / data-memory sequencer.
// The FSM walks IDLE -> REQ -> (WAIT) -> WB for every lw/sw.
package wb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_port_sequencer_if.sv
// Bundles the decoder, data-memory and register-file write-port signals.
// master = the sequencer, slave = the surrounding datapath/memory.
interface wb_port_sequencer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      INSTR_VALID;
  logic                      REG_WRITE;
  logic                      MEM_TO_REG;
  logic                      MEM_WRITE;
  logic [REG_ADDR_WIDTH-1:0] WRITE_REG;
  logic [DATA_WIDTH-1:0]     ALU_RESULT;
  logic [DATA_WIDTH-1:0]     WRITE_DATA;

  logic                      MEM_REQ;
  logic                      MEM_WE;
  logic [DATA_WIDTH-1:0]     MEM_ADDR;
  logic [DATA_WIDTH-1:0]     MEM_WDATA;
  logic                      MEM_GNT;
  logic                      MEM_RVALID;
  logic [DATA_WIDTH-1:0]     MEM_RDATA;

  logic                      REG_FILE_WE3;
  logic [REG_ADDR_WIDTH-1:0] REG_FILE_A3;
  logic                      REG_FILE_WD3_SEL;
  logic [DATA_WIDTH-1:0]     DATA_MEM_RD_Q;
  logic                      STALL;
  logic                      BUS_ERR;

  modport master (
    input  INSTR_VALID, REG_WRITE, MEM_TO_REG, MEM_WRITE, WRITE_REG,
    input  ALU_RESULT, WRITE_DATA,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_GNT, MEM_RVALID, MEM_RDATA,
    output REG_FILE_WE3, REG_FILE_A3, REG_FILE_WD3_SEL, DATA_MEM_RD_Q,
    output STALL, BUS_ERR
  );

  modport slave (
    output INSTR_VALID, REG_WRITE, MEM_TO_REG, MEM_WRITE, WRITE_REG,
    output ALU_RESULT, WRITE_DATA,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_GNT, MEM_RVALID, MEM_RDATA,
    input  REG_FILE_WE3, REG_FILE_A3, REG_FILE_WD3_SEL, DATA_MEM_RD_Q,
    input  STALL, BUS_ERR
  );

endinterface

// File: rtl/wb_port_sequencer.sv
// Register-file write-port and data-memory handshake sequencer for a MIPS core.
// ALU ops write back in the same cycle; lw/sw stall the PC through REQ/WAIT/WB.
module wb_port_sequencer
  import wb_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               CLK,
  input logic               RST,
  wb_port_sequencer_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [REG_ADDR_WIDTH-1:0] RZ = REG_ADDR_WIDTH'(REG_ZERO);

  state_t state, next_state;

  logic [DATA_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      store_q;
  logic                      timed_out_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;
  logic                      bus_err_q;

  logic                      mem_op;
  logic                      timeout_reached;
  logic                      latch_en;
  logic                      capture_en;
  logic                      timeout_hit;

  logic                      mem_req;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      we3;
  logic [REG_ADDR_WIDTH-1:0] a3;
  logic                      wd3_sel;
  logic                      stall;

  assign mem_op          = bus.INSTR_VALID & (bus.MEM_TO_REG | bus.MEM_WRITE);
  assign timeout_reached = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Reset gates every output combinationally so MEM_REQ drops in the reset cycle itself.
  always_comb begin
    next_state  = state;
    latch_en    = 1'b0;
    capture_en  = 1'b0;
    timeout_hit = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    we3         = 1'b0;
    a3          = '0;
    wd3_sel     = 1'b0;
    stall       = 1'b0;
    if (RST) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            stall      = 1'b1;
            latch_en   = 1'b1;
            next_state = REQ;
          end else begin
            we3 = bus.INSTR_VALID & bus.REG_WRITE & (bus.WRITE_REG != RZ);
            a3  = bus.INSTR_VALID ? bus.WRITE_REG : '0;
          end
        end
        REQ: begin
          mem_req   = 1'b1;
          mem_we    = store_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          stall     = 1'b1;
          if (bus.MEM_GNT && (store_q || bus.MEM_RVALID)) begin
            capture_en = ~store_q;
            next_state = WB;
          end else if (timeout_reached) begin
            timeout_hit = 1'b1;
            next_state  = WB;
          end else if (bus.MEM_GNT) begin
            next_state = WAIT;
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (bus.MEM_RVALID) begin
            capture_en = 1'b1;
            next_state = WB;
          end else if (timeout_reached) begin
            timeout_hit = 1'b1;
            next_state  = WB;
          end
        end
        WB: begin
          we3        = ~store_q & ~timed_out_q & (rd_q != RZ);
          a3         = rd_q;
          wd3_sel    = ~store_q;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // The counter only matters while in REQ/WAIT; it is re-cleared when each new op is latched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      if (latch_en) begin
        addr_q      <= bus.ALU_RESULT;
        wdata_q     <= bus.WRITE_DATA;
        rd_q        <= bus.WRITE_REG;
        store_q     <= bus.MEM_WRITE;
        timed_out_q <= 1'b0;
        cnt_q       <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture_en) rd_data_q <= bus.MEM_RDATA;
      if (timeout_hit) begin
        bus_err_q   <= 1'b1;
        timed_out_q <= 1'b1;
      end
    end
  end

  assign bus.MEM_REQ          = mem_req;
  assign bus.MEM_WE           = mem_we;
  assign bus.MEM_ADDR         = mem_addr;
  assign bus.MEM_WDATA        = mem_wdata;
  assign bus.REG_FILE_WE3     = we3;
  assign bus.REG_FILE_A3      = a3;
  assign bus.REG_FILE_WD3_SEL = wd3_sel;
  assign bus.DATA_MEM_RD_Q    = rd_data_q;
  assign bus.STALL            = stall;
  assign bus.BUS_ERR          = bus_err_q;

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Scoreboard bench: a driver issues instructions and pushes expected retirements,
// a memory responder answers the bus, and a monitor checks each retirement.
module tb_wb_port_sequencer;

  localparam int DW = 32;
  localparam int RAW = 5;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  wb_port_sequencer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

  wb_port_sequencer #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic        sel;
    logic        is_load;
    logic [31:0] data;
    int          stall;
    logic        bus_err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt;
    int          rv;
    bit          never;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  bit resp_en = 1'b0;

  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  logic [31:0] model_last_ld = 32'h0;
  logic        model_bus_err = 1'b0;

  // Contents of never-written memory words, shared by the model and the responder.
  function automatic logic [31:0] fill(logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  // Computes the architectural outcome of one instruction, then drives it until it retires.
  task automatic applyStimulus(logic rw, logic m2r, logic mw, logic [4:0] rd,
                               logic [31:0] alu, logic [31:0] wd, int g, int r, bit never);
    exp_t e;
    mem_t m;
    bit   store, load, ok;
    int   cyc;
    store = mw;
    load  = m2r && !mw;
    e.a3 = rd;
    e.is_load = load;
    if (m2r || mw) begin
      ok = !never && ((g + 1 + (store ? 0 : r)) <= TO);
      m.we = store; m.addr = alu; m.wdata = wd; m.gnt = g; m.rv = r; m.never = !ok;
      mem_q.push_back(m);
      e.stall = ok ? (2 + g + (store ? 0 : r)) : (1 + TO);
      if (!ok) model_bus_err = 1'b1;
      if (store && ok) model_mem[alu] = wd;
      if (load && ok) model_last_ld = model_mem.exists(alu) ? model_mem[alu] : fill(alu);
      e.we3 = load && ok && (rd != 5'd0);
      e.sel = 1'b1;
    end else begin
      e.stall = 0;
      e.we3 = rw && (rd != 5'd0);
      e.sel = 1'b0;
    end
    e.data = model_last_ld;
    e.bus_err = model_bus_err;
    exp_q.push_back(e);

    bus.INSTR_VALID = 1'b1;
    bus.REG_WRITE   = rw;
    bus.MEM_TO_REG  = m2r;
    bus.MEM_WRITE   = mw;
    bus.WRITE_REG   = rd;
    bus.ALU_RESULT  = alu;
    bus.WRITE_DATA  = wd;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (bus.STALL && cyc < 64);
    if (bus.STALL) checkOutput("retire_bound", 32'(bus.STALL), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every STALL=0 cycle with a valid instruction is one retirement.
  initial begin : monitor
    exp_t e;
    int stalls;
    stalls = 0;
    forever begin
      @(negedge CLK);
      if (!mon_en || !bus.INSTR_VALID) begin
        stalls = 0;
      end else if (bus.STALL) begin
        stalls++;
      end else begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("stall_cycles", 32'(stalls), 32'(e.stall));
          checkOutput("we3", 32'(bus.REG_FILE_WE3), 32'(e.we3));
          if (e.we3) begin
            checkOutput("a3", 32'(bus.REG_FILE_A3), 32'(e.a3));
            checkOutput("wd3_sel", 32'(bus.REG_FILE_WD3_SEL), 32'(e.sel));
          end
          checkOutput("bus_err", 32'(bus.BUS_ERR), 32'(e.bus_err));
          checkOutput("mem_req_retire", 32'(bus.MEM_REQ), 32'd0);
          if (e.is_load) checkOutput("rd_q", bus.DATA_MEM_RD_Q, e.data);
        end
        stalls = 0;
      end
    end
  end

  // Memory responder: checks the request, then grants/returns data after the chosen delays.
  initial begin : responder
    mem_t m;
    int k;
    bus.MEM_GNT = 1'b0;
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (resp_en && bus.MEM_REQ) begin
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_req", 32'd1, 32'd0);
        end else begin
          m = mem_q.pop_front();
          checkOutput("mem_addr", bus.MEM_ADDR, m.addr);
          checkOutput("mem_we", 32'(bus.MEM_WE), 32'(m.we));
          if (m.we) checkOutput("mem_wdata", bus.MEM_WDATA, m.wdata);
          if (m.never) begin
            k = 0;
            while (bus.MEM_REQ && k < 40) begin
              @(negedge CLK);
              k++;
            end
            if (bus.MEM_REQ) checkOutput("timeout_bound", 32'(bus.MEM_REQ), 32'd0);
          end else begin
            for (int i = 0; i < m.gnt; i++) begin
              @(negedge CLK);
              checkOutput("req_held", 32'(bus.MEM_REQ), 32'd1);
              checkOutput("addr_held", bus.MEM_ADDR, m.addr);
            end
            bus.MEM_GNT = 1'b1;
            if (m.we) resp_mem[m.addr] = m.wdata;
            else if (m.rv == 0) begin
              bus.MEM_RVALID = 1'b1;
              bus.MEM_RDATA = resp_mem.exists(m.addr) ? resp_mem[m.addr] : fill(m.addr);
            end
            @(posedge CLK);
            #1;
            bus.MEM_GNT = 1'b0;
            bus.MEM_RVALID = 1'b0;
            bus.MEM_RDATA = $urandom;
            if (!m.we && m.rv > 0) begin
              for (int i = 1; i < m.rv; i++) begin
                @(posedge CLK);
                #1;
              end
              bus.MEM_RVALID = 1'b1;
              bus.MEM_RDATA = resp_mem.exists(m.addr) ? resp_mem[m.addr] : fill(m.addr);
              @(posedge CLK);
              #1;
              bus.MEM_RVALID = 1'b0;
              bus.MEM_RDATA = $urandom;
            end
          end
        end
      end
    end
  end

  task automatic checkIdleOutputs(string tag);
    checkOutput({tag, "_stall"}, 32'(bus.STALL), 32'd0);
    checkOutput({tag, "_we3"}, 32'(bus.REG_FILE_WE3), 32'd0);
    checkOutput({tag, "_a3"}, 32'(bus.REG_FILE_A3), 32'd0);
    checkOutput({tag, "_sel"}, 32'(bus.REG_FILE_WD3_SEL), 32'd0);
    checkOutput({tag, "_req"}, 32'(bus.MEM_REQ), 32'd0);
    checkOutput({tag, "_addr"}, bus.MEM_ADDR, 32'd0);
    checkOutput({tag, "_rdq"}, bus.DATA_MEM_RD_Q, 32'd0);
    checkOutput({tag, "_buserr"}, 32'(bus.BUS_ERR), 32'd0);
  endtask

  initial begin : driver
    int kind, g, r;
    logic [4:0] rd;
    logic [31:0] addr;
    RST = 1'b1;
    bus.INSTR_VALID = 1'b0;
    bus.REG_WRITE = 1'b0;
    bus.MEM_TO_REG = 1'b0;
    bus.MEM_WRITE = 1'b0;
    bus.WRITE_REG = '0;
    bus.ALU_RESULT = '0;
    bus.WRITE_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkIdleOutputs("reset");
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    resp_en = 1'b1;

    applyStimulus(1, 0, 0, 5'd8, 32'h0000_0123, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 1, 5'd0, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus(1, 1, 0, 5'd9, 32'h0000_0040, 32'h0, 2, 3, 0);
    applyStimulus(0, 0, 1, 5'd0, 32'h0000_0010, 32'h0000_1234, 0, 0, 0);
    applyStimulus(1, 1, 0, 5'd5, 32'h0000_0010, 32'h0, 0, 0, 0);
    applyStimulus(1, 1, 0, 5'd0, 32'h0000_0040, 32'h0, 1, 1, 0);
    applyStimulus(0, 0, 1, 5'd0, 32'h0000_0008, 32'h5555_AAAA, TO - 1, 0, 0);
    applyStimulus(1, 1, 1, 5'd4, 32'h0000_0020, 32'h0BAD_F00D, 0, 0, 0);
    applyStimulus(1, 1, 0, 5'd6, 32'h0000_0020, 32'h0, 1, 2, 0);
    applyStimulus(1, 1, 0, 5'd7, 32'h0000_0030, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 5'd3, 32'h0, 32'h0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      addr = {27'd0, 3'($urandom), 2'b00};
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      case (kind)
        0, 1: applyStimulus(1'($urandom), 0, 0, rd, $urandom, $urandom, 0, 0, 0);
        2: applyStimulus(1, 1, 0, rd, addr, $urandom, g, r, ($urandom_range(0, 15) == 0));
        default: applyStimulus(0, 0, 1, rd, addr, $urandom, g, r, 0);
      endcase
    end

    bus.INSTR_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
    mon_en = 1'b0;
    resp_en = 1'b0;

    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkIdleOutputs("rst2");

    @(posedge CLK);
    #1;
    bus.INSTR_VALID = 1'b1;
    bus.REG_WRITE = 1'b1;
    bus.MEM_TO_REG = 1'b1;
    bus.MEM_WRITE = 1'b0;
    bus.WRITE_REG = 5'd12;
    bus.ALU_RESULT = 32'h0000_0044;
    @(posedge CLK);
    #1;
    bus.MEM_GNT = 1'b1;
    @(negedge CLK);
    checkOutput("wait_req_granted", 32'(bus.MEM_REQ), 32'd1);
    @(posedge CLK);
    #1;
    bus.MEM_GNT = 1'b0;
    @(negedge CLK);
    checkOutput("wait_stall", 32'(bus.STALL), 32'd1);
    checkOutput("wait_req_low", 32'(bus.MEM_REQ), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    checkIdleOutputs("midrst");
    @(posedge CLK);
    #1;
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA = 32'hCAFE_F00D;
    @(negedge CLK);
    checkOutput("late_rvalid_we3", 32'(bus.REG_FILE_WE3), 32'd0);
    @(posedge CLK);
    #1;
    bus.MEM_RVALID = 1'b0;
    @(negedge CLK);
    checkOutput("late_rvalid_rdq", bus.DATA_MEM_RD_Q, 32'd0);
    checkOutput("late_rvalid_stall", 32'(bus.STALL), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
